// File: rtl/fp_pack_round_if.sv
// Handshake and data bundle between the FP datapath tail and the packer.
// The slave modport is the packer; the master modport is the producer/consumer side.
interface fp_pack_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [27:0] sig_i;
  logic        nan_i;
  logic        inf_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  modport slave (
    input  in_valid, sign_i, exp_i, sig_i, nan_i, inf_i, out_ready,
    output in_ready, out_valid, result_o, overflow_o, underflow_o, inexact_o
  );

  modport master (
    output in_valid, sign_i, exp_i, sig_i, nan_i, inf_i, out_ready,
    input  in_ready, out_valid, result_o, overflow_o, underflow_o, inexact_o
  );
endinterface

// File: rtl/fp_pack_round.sv
// Packs an unpacked FP result into binary32: iterative normalize/denormalize,
// round-to-nearest-even, then encode zero/subnormal/normal/inf/NaN.
module fp_pack_round (
  input  logic           clk,
  input  logic           rst,
  fp_pack_round_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StOut} state_e;
  typedef enum logic [1:0] {KindNum, KindZero, KindInf, KindNan} kind_e;

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d, kind_in;
  logic               sign_q, sign_d;
  logic signed [11:0] exp_q, exp_d;
  logic [27:0]        sig_q, sig_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic               lsb, grd, rs, inc;
  logic [24:0]        m;
  logic [23:0]        mant;
  logic signed [11:0] exp_r;
  logic [7:0]         exp_field;
  logic               rnd_ovf, rnd_inx;

  // Rounding datapath, consumed only in StRound.
  always_comb begin
    lsb       = sig_q[3];
    grd       = sig_q[2];
    rs        = sig_q[1] | sig_q[0];
    inc       = grd & (rs | lsb);
    m         = {1'b0, sig_q[26:3]} + {24'b0, inc};
    mant      = m[24] ? m[24:1] : m[23:0];
    exp_r     = m[24] ? exp_q + 12'sd1 : exp_q;
    exp_field = mant[23] ? exp_r[7:0] : 8'd0;
    rnd_ovf   = mant[23] && (exp_r >= 12'sd255);
    rnd_inx   = grd | rs | rnd_ovf;
  end

  always_comb begin
    if (bus.nan_i)              kind_in = KindNan;
    else if (bus.inf_i)         kind_in = KindInf;
    else if (bus.sig_i == '0)   kind_in = KindZero;
    else                        kind_in = KindNum;
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d  = bus.sign_i;
          exp_d   = {{2{bus.exp_i[9]}}, bus.exp_i};
          sig_d   = bus.sig_i;
          kind_d  = kind_in;
          state_d = (kind_in == KindNum) ? StShift : StRound;
        end
      end
      StShift: begin
        if (sig_q[27]) begin
          sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + 12'sd1;
        end else if (exp_q < -12'sd30) begin
          // Too deep for subnormal range: only stickiness survives.
          sig_d = {27'b0, |sig_q};
          exp_d = 12'sd1;
        end else if (exp_q < 12'sd1) begin
          sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + 12'sd1;
        end else if (!sig_q[26] && (exp_q > 12'sd1)) begin
          sig_d = {sig_q[26:0], 1'b0};
          exp_d = exp_q - 12'sd1;
        end else begin
          state_d = StRound;
        end
      end
      StRound: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        unique case (kind_q)
          KindNan:  result_d = 32'h7FC0_0000;
          KindInf:  result_d = {sign_q, 8'hFF, 23'b0};
          KindZero: result_d = {sign_q, 31'b0};
          default: begin
            if (rnd_ovf) result_d = {sign_q, 8'hFF, 23'b0};
            else         result_d = {sign_q, exp_field, mant[22:0]};
            ovf_d = rnd_ovf;
            inx_d = rnd_inx;
            unf_d = !sig_q[26] && rnd_inx;
          end
        endcase
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      kind_q   <= KindNum;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StOut);
  assign bus.result_o    = result_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.inexact_o   = inx_q;

endmodule
